div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 divider in the execute stage, covering RV32M DIV/DIVU/REM/REMU.
- Takes the same SrcA/SrcB operands that feed the single-cycle ALU; its result goes to the downstream execute-result mux (EX/MEM input).
- Asserts Busy_o so the hazard unit can stall upstream stages while a division is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be ≥ 4 and even.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- Start_i  in  1  request; sampled only in IDLE or DONE.
- Flush_i  in  1  synchronous abort from the hazard unit.
- DivOp_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcA_i  in  DATA_WIDTH  dividend.
- SrcB_i  in  DATA_WIDTH  divisor.
- Busy_o  out  1  high in CALC and FIX states.
- Done_o  out  1  one-cycle pulse; Result_o valid in that cycle.
- Result_o  out  DATA_WIDTH  quotient or remainder; held until the next accepted Start_i.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; Busy_o=0, Done_o=0, Result_o=0; counter and all datapath registers cleared.
- States: IDLE, CALC, FIX, DONE.
- Start acceptance:
  - Start_i=1 in IDLE or DONE with Flush_i=0 latches SrcA_i, SrcB_i and DivOp_i.
  - Start_i in CALC/FIX is ignored.
  - Start_i in DONE gives back-to-back operation: that cycle's Done_o still pulses.
- Signed ops (DIV/REM): operands are converted to magnitudes on accept; quotient sign = signA XOR signB; remainder sign = signA.
- Special cases, checked at accept; next state DONE with Result_o loaded directly:
  - Divisor 0: quotient = all ones; remainder = SrcA_i.
  - DIV/REM with SrcA_i = most-negative value and SrcB_i = -1: quotient = SrcA_i; remainder = 0.
- Normal path, accept → CALC with counter = DATA_WIDTH:
  - Restoring step each cycle: shift {rem, quo} left by 1; subtract divisor from rem; if non-negative keep the difference and set the quo LSB, else restore.
  - Counter decrements; when it reaches 0 go to FIX.
- FIX: applies sign correction and selects quotient or remainder into Result_o; next state DONE.
- DONE: Done_o=1 for exactly one cycle; next IDLE, or CALC/DONE if a new Start_i is accepted.
- Latency, Start_i edge to Done_o high:
  - Special case: 1 cycle.
  - Normal: DATA_WIDTH+2 cycles (34 at default).
  - Cycles per op are fixed; no data-dependent variation except the optional feature below.
- Flush_i=1 in any state:
  - Next state IDLE; no Done_o pulse; Result_o unchanged.
  - Flush_i overrides a simultaneous Start_i.
- Result_o changes only in FIX, or on entry to DONE for special cases.
- Datapath widths: remainder register is DATA_WIDTH+1 bits so the trial subtraction's sign bit is visible. Unsigned ops use operands as-is.
- Reset mid-operation: immediate return to reset values; no Done_o pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: on accept, if |dividend| < |divisor| (after sign handling), go straight to DONE with quotient 0 and remainder = SrcA_i, giving 1-cycle latency.
- Not defined: such operands take the full DATA_WIDTH+2 cycles and produce identical results.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- DIV SrcA=-7 (0xFFFFFFF9), SrcB=2 → Result_o=0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1). Done_o 34 cycles after Start_i; Busy_o high for 33 cycles.
- DIVU 0xFFFFFFFF / 0x00000010 → 0x0FFFFFFF; REMU same operands → 0x0000000F.
- Divide by zero, DIV 0x00001234 / 0 → 0xFFFFFFFF; REM 0x00001234 / 0 → 0x00001234. Done_o exactly 1 cycle after Start_i.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0x00000000. 1-cycle latency.
- Flush_i pulsed 10 cycles into a DIVU → state IDLE next cycle, Busy_o=0, no Done_o, Result_o keeps the previous value. An immediately following Start_i (DIVU 100/7) → 14 after 34 cycles.
- Back-to-back: Start_i held high in the DONE cycle with REMU 100/7 → first Done_o observed, second op returns 2. With DIV_EARLY_OUT_EN, DIVU 3/9 → 0 in 1 cycle; without it, 0 in 34 cycles.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Operates on the execute-stage operands and raises Busy_o while a
//            division is in flight so upstream stages can be stalled.
// Options  : DIV_EARLY_OUT_EN - finish in one cycle when |dividend| < |divisor|.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  Start_i,
  input  logic                  Flush_i,
  input  logic [1:0]            DivOp_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W:0]           rem_q, rem_d;     // extra MSB exposes the trial sign
  logic [W-1:0]         quo_q, quo_d;     // dividend magnitude shifts out, quotient shifts in
  logic [W-1:0]         dvs_q, dvs_d;     // divisor magnitude
  logic [W-1:0]         res_q, res_d;
  logic                 negq_q, negq_d;   // quotient must be negated in FIX
  logic                 negr_q, negr_d;   // remainder must be negated in FIX
  logic                 isrem_q, isrem_d; // REM/REMU selects the remainder

  logic         accept;
  logic         signed_op;
  logic         sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;
  logic         div_zero, ovf, early, special;
  logic [W-1:0] special_res;
  logic [W+1:0] trial;
  logic [W-1:0] q_fix, r_fix;

  // Operand decode: magnitudes, special-case detection and direct results
  always_comb begin
    accept    = Start_i && !Flush_i && (state_q == ST_IDLE || state_q == ST_DONE);
    signed_op = ~DivOp_i[0];
    sign_a    = signed_op & SrcA_i[W-1];
    sign_b    = signed_op & SrcB_i[W-1];
    mag_a     = sign_a ? (~SrcA_i + 1'b1) : SrcA_i;
    mag_b     = sign_b ? (~SrcB_i + 1'b1) : SrcB_i;
    div_zero  = (SrcB_i == '0);
    ovf       = signed_op && (SrcA_i == MOST_NEG) && (SrcB_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (mag_a < mag_b);
`else
    early     = 1'b0;
`endif
    special   = div_zero | ovf | early;
    if (DivOp_i[1]) begin
      special_res = ovf ? '0 : SrcA_i;
    end else if (div_zero) begin
      special_res = '1;
    end else if (ovf) begin
      special_res = SrcA_i;
    end else begin
      special_res = '0;
    end
    // Shifted partial remainder minus divisor; MSB set means "restore"
    trial = {rem_q, quo_q[W-1]} - {2'b00, dvs_q};
    q_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = negr_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;

    if (accept) begin
      negq_d  = sign_a ^ sign_b;
      negr_d  = sign_a;
      isrem_d = DivOp_i[1];
      dvs_d   = mag_b;
      quo_d   = mag_a;
      rem_d   = '0;
      cnt_d   = CNT_WIDTH'(W);
      if (special) begin
        res_d   = special_res;
        state_d = ST_DONE;
      end else begin
        state_d = ST_CALC;
      end
    end

    case (state_q)
      ST_CALC: begin
        cnt_d = cnt_q - 1'b1;
        quo_d = {quo_q[W-2:0], ~trial[W+1]};
        rem_d = trial[W+1] ? {rem_q[W-1:0], quo_q[W-1]} : trial[W:0];
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        res_d   = isrem_q ? r_fix : q_fix;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    // Abort wins over everything and leaves the last result visible
    if (Flush_i) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    Busy_o   = (state_q == ST_CALC) || (state_q == ST_FIX);
    Done_o   = (state_q == ST_DONE);
    Result_o = res_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: directed plan vectors, flush,
//            reset, back-to-back and randomized operations against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int W = 32;
  localparam int NORM_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  wire          Busy;
  wire          Done;
  wire  [W-1:0] Result;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .Start_i  (Start),
    .Flush_i  (Flush),
    .DivOp_i  (op),
    .SrcA_i   (a),
    .SrcB_i   (b),
    .Busy_o   (Busy),
    .Done_o   (Done),
    .Result_o (Result)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my;
    mx = (!o[0] && x[31]) ? -x : x;
    my = (!o[0] && y[31]) ? -y : y;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mx < my) return 1;
`else
    if (mx < my) return NORM_LAT;
`endif
    return NORM_LAT;
  endfunction

  // Issue one operation and wait (bounded) for Done; lat=-1 on timeout
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int busy);
    @(posedge clk); #1;
    op = o; a = x; b = y; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 1;
    busy = 0;
    while (!Done && lat < 200) begin
      if (Busy) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!Done) lat = -1;
    res = Result;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b result=%h required 0/0/00000000", Busy, Done, Result);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b done=%b required 0/0", Busy, Done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [12] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
    logic [31:0] t_a  [12] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000,
                               32'd3, 32'd100, 32'd100, 32'd7};
    logic [31:0] t_b  [12] = '{32'd2, 32'd2, 32'h10, 32'h10, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd7, 32'd7, 32'hFFFF_FFFE};
    logic [31:0] t_e  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0000_000F,
                               32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0000_0000,
                               32'd0, 32'd14, 32'd2, 32'hFFFF_FFFD};
    logic [31:0] res;
    int lat, busy;
    for (int i = 0; i < 12; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, lat, busy);
      n_vec++;
      if (res !== t_e[i]) begin
        n_err++;
        $display("FAIL directed_%0d result: got %h required %h", i, res, t_e[i]);
      end
      n_vec++;
      if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin
        n_err++;
        $display("FAIL directed_%0d latency: got %0d required %0d", i, lat, exp_lat(t_op[i], t_a[i], t_b[i]));
      end
      if (i == 0) begin
        n_vec++;
        if (busy != NORM_LAT - 1) begin
          n_err++;
          $display("FAIL directed_busy: got %0d cycles required %0d", busy, NORM_LAT - 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int lat;
    prev = Result;
    @(posedge clk); #1;
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== prev) begin
      n_err++;
      $display("FAIL flush: got busy=%b done=%b result=%h required 0/0/%h", Busy, Done, Result, prev);
    end
    op = 2'd1; a = 32'd100; b = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (!Done || lat != NORM_LAT || Result !== 32'd14) begin
      n_err++;
      $display("FAIL flush_restart: got done=%b lat=%0d result=%h required 1/%0d/0000000e", Done, lat, Result, NORM_LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(posedge clk); #1;
    op = 2'd0; a = 32'hFFFF_FFF9; b = 32'd2; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (!Done || Result !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b result=%h required 1/fffffffd", Done, Result);
    end
    // New request presented while Done_o is high
    op = 2'd3; a = 32'd100; b = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (!Done || lat != NORM_LAT || Result !== 32'd2) begin
      n_err++;
      $display("FAIL b2b_second: got done=%b lat=%0d result=%h required 1/%0d/00000002", Done, lat, Result, NORM_LAT);
    end
    // Chain into a special case straight out of DONE
    op = 2'd0; a = 32'd5; b = 32'd0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    n_vec++;
    if (Done !== 1'b1 || Result !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL b2b_special: got done=%b result=%h required 1/ffffffff", Done, Result);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    @(posedge clk); #1;
    op = 2'd1; a = 32'd1000; b = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0) begin
      n_err++;
      $display("FAIL reset_midop: got busy=%b done=%b result=%h required 0/0/00000000", Busy, Done, Result);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y, res;
    int lat, busy, kind;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) y = 32'd0;
      else if (kind == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (kind == 2) y = 32'($urandom_range(1, 15)) ^ ({32{y[31]}});
      else if (kind == 3) x = 32'($urandom_range(0, 1000));
      run_op(o, x, y, res, lat, busy);
      n_vec++;
      if (res !== ref_div(o, x, y)) begin
        n_err++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h required %h", i, o, x, y, res, ref_div(o, x, y));
      end
      n_vec++;
      if (lat != exp_lat(o, x, y)) begin
        n_err++;
        $display("FAIL random_%0d latency: got %0d required %0d", i, lat, exp_lat(o, x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
